// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM stage: access sizes, writeback select,
// access FSM states and the control half of the stage register.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_LOAD = 2'd1,
        WB_NPC  = 2'd2,
        WB_RSVD = 2'd3
    } wbsel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } fsm_t;

    // Control fields of the instruction held in MEM; wide data fields live
    // beside it in the top so their widths can follow the parameters.
    typedef struct packed {
        logic   valid;
        logic   reg_wr;
        wbsel_t reg_sel;
        logic   d_ren;
        logic   d_wen;
        size_t  size;
        logic   sgn;
        logic   misalign;
    } mem_req_t;

    localparam mem_req_t REQ_NONE = '{
        valid:    1'b0,
        reg_wr:   1'b0,
        reg_sel:  WB_ALU,
        d_ren:    1'b0,
        d_wen:    1'b0,
        size:     SZ_BYTE,
        sgn:      1'b0,
        misalign: 1'b0
    };

    // Number of bytes touched by an access of the given size.
    function automatic logic [3:0] bytes_of(input size_t size);
        case (size)
            SZ_BYTE:  bytes_of = 4'd1;
            SZ_HALF:  bytes_of = 4'd2;
            SZ_WORD:  bytes_of = 4'd4;
            SZ_DWORD: bytes_of = 4'd8;
            default:  bytes_of = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data port: load extraction with zero/sign
// extension, store replication across the word and byte-enable generation.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] lane,
    input  size_t                       size,
    input  logic                        sgn,
    input  logic [DATA_W-1:0]           ld_raw,
    input  logic [DATA_W-1:0]           st_raw,
    output logic [DATA_W-1:0]           ld_ext,
    output logic [DATA_W-1:0]           st_rep,
    output logic [DATA_W/8-1:0]         byte_en
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] shifted_s;
    logic              sign_s;
    logic [3:0]        nbytes_s;
    logic [7:0]        base_mask_s;
    logic [NB-1:0]     mask_s;

    // Move the addressed lane down to byte 0, keep size bytes, fill the rest.
    always_comb begin
        shifted_s = ld_raw >> {lane, 3'b000};
        nbytes_s  = bytes_of(size);
        sign_s    = 1'b0;
        ld_ext    = {DATA_W{1'b0}};
        case (size)
            SZ_BYTE:  sign_s = shifted_s[7];
            SZ_HALF:  sign_s = shifted_s[15];
            SZ_WORD:  sign_s = shifted_s[31];
            SZ_DWORD: sign_s = shifted_s[DATA_W-1];
            default:  sign_s = 1'b0;
        endcase
        for (int i = 0; i < NB; i++) begin
            if (i < int'(nbytes_s)) begin
                ld_ext[i*8 +: 8] = shifted_s[i*8 +: 8];
            end else begin
                ld_ext[i*8 +: 8] = {8{sgn & sign_s}};
            end
        end
    end

    // Replicate the low store bytes into every lane and place the enable mask.
    always_comb begin
        st_rep      = st_raw;
        base_mask_s = 8'h01;
        case (size)
            SZ_BYTE:  st_rep = {NB{st_raw[7:0]}};
            SZ_HALF:  st_rep = {(NB/2){st_raw[15:0]}};
            SZ_WORD:  st_rep = {(NB/4){st_raw[31:0]}};
            default:  st_rep = st_raw;
        endcase
        case (size)
            SZ_BYTE:  base_mask_s = 8'h01;
            SZ_HALF:  base_mask_s = 8'h03;
            SZ_WORD:  base_mask_s = 8'h0F;
            SZ_DWORD: base_mask_s = 8'hFF;
            default:  base_mask_s = 8'h01;
        endcase
        mask_s  = base_mask_s[NB-1:0];
        byte_en = mask_s << lane;
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM/WB stage: holds the instruction in MEM, runs its data access as a
// request/hit handshake (stalling upstream meanwhile) and registers the
// selected writeback value onto the WB-side outputs.
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PC_W   = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                flush,
    input  logic                stall_in,
    input  logic                in_valid,
    input  logic                in_regWr,
    input  logic [REG_W-1:0]    in_regDst,
    input  logic [1:0]          in_regSel,
    input  logic [PC_W-1:0]     in_nPC,
    input  logic [DATA_W-1:0]   in_ALUOut,
    input  logic                in_dREN,
    input  logic                in_dWEN,
    input  logic [1:0]          in_size,
    input  logic                in_signed,
    input  logic [DATA_W-1:0]   in_store,
    output logic                dmemREN,
    output logic                dmemWEN,
    output logic [DATA_W-1:0]   dmemaddr,
    output logic [DATA_W-1:0]   dmemstore,
    output logic [DATA_W/8-1:0] dmembyteen,
    input  logic [DATA_W-1:0]   dmemload,
    input  logic                dhit,
    output logic                mem_stall,
    output logic                out_valid,
    output logic                out_regWr,
    output logic [REG_W-1:0]    out_regDst,
    output logic [DATA_W-1:0]   out_wdata,
    output logic                out_misalign
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);

    mem_req_t          req_r;
    mem_req_t          req_in_s;
    logic [REG_W-1:0]  dst_r;
    logic [PC_W-1:0]   npc_r;
    logic [DATA_W-1:0] addr_r;
    logic [DATA_W-1:0] store_r;
    logic [DATA_W-1:0] ld_r;
    fsm_t              state_r;
    fsm_t              state_nxt_s;

    logic              access_s;
    logic              advance_s;
    logic              mis_s;
    logic              need_s;
    logic [3:0]        in_bytes_s;
    logic [3:0]        low_bits_s;
    logic [DATA_W-1:0] ld_ext_s;
    logic [DATA_W-1:0] st_rep_s;
    logic [DATA_W-1:0] npc_ext_s;
    logic [DATA_W-1:0] wb_data_s;
    logic [NB-1:0]     byte_en_s;

    assign access_s  = (state_r == ACCESS);
    assign advance_s = ~access_s & ~stall_in;
    assign mem_stall = access_s;

    // Request side is decoded purely from registered state; a load+store is a store.
    assign dmemREN    = access_s & req_r.d_ren & ~req_r.d_wen;
    assign dmemWEN    = access_s & req_r.d_wen;
    assign dmemaddr   = {addr_r[DATA_W-1:LANE_W], {LANE_W{1'b0}}};
    assign dmemstore  = st_rep_s;
    assign dmembyteen = (access_s & req_r.d_wen) ? byte_en_s : {NB{1'b0}};

    generate
        if (PC_W >= DATA_W) begin : g_npc_trunc
            assign npc_ext_s = npc_r[DATA_W-1:0];
        end else begin : g_npc_zext
            assign npc_ext_s = {{(DATA_W-PC_W){1'b0}}, npc_r};
        end
    endgenerate

    mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .lane    (addr_r[LANE_W-1:0]),
        .size    (req_r.size),
        .sgn     (req_r.sgn),
        .ld_raw  (dmemload),
        .st_raw  (store_r),
        .ld_ext  (ld_ext_s),
        .st_rep  (st_rep_s),
        .byte_en (byte_en_s)
    );

    // Classify the incoming instruction: misalignment and whether it needs the bus.
    always_comb begin
        in_bytes_s = bytes_of(size_t'(in_size));
        low_bits_s = {1'b0, in_ALUOut[2:0]} & (in_bytes_s - 4'd1);
        mis_s      = (in_dREN | in_dWEN) &
                     ((low_bits_s != 4'd0) | ((in_size == 2'd3) & (DATA_W == 32)));
        need_s     = in_valid & (in_dREN | in_dWEN) & ~mis_s;
        req_in_s          = REQ_NONE;
        req_in_s.valid    = in_valid;
        req_in_s.reg_wr   = in_regWr;
        req_in_s.reg_sel  = wbsel_t'(in_regSel);
        req_in_s.d_ren    = in_dREN;
        req_in_s.d_wen    = in_dWEN;
        req_in_s.size     = size_t'(in_size);
        req_in_s.sgn      = in_signed;
        req_in_s.misalign = mis_s;
    end

    // Writeback value for the instruction currently held in MEM.
    always_comb begin
        wb_data_s = addr_r;
        case (req_r.reg_sel)
            WB_LOAD: wb_data_s = ld_r;
            WB_NPC:  wb_data_s = npc_ext_s;
            default: wb_data_s = addr_r;
        endcase
    end

    // Stage register R: capture EX results on advance, invalidate on flush.
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_r   <= REQ_NONE;
            dst_r   <= {REG_W{1'b0}};
            npc_r   <= {PC_W{1'b0}};
            addr_r  <= {DATA_W{1'b0}};
            store_r <= {DATA_W{1'b0}};
        end else if (flush) begin
            req_r   <= REQ_NONE;
        end else if (advance_s) begin
            req_r   <= req_in_s;
            dst_r   <= in_regDst;
            npc_r   <= in_nPC;
            addr_r  <= in_ALUOut;
            store_r <= in_store;
        end
    end

    // WB-side outputs: registered from R when the stage advances.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            out_valid    <= 1'b0;
            out_regWr    <= 1'b0;
            out_regDst   <= {REG_W{1'b0}};
            out_wdata    <= {DATA_W{1'b0}};
            out_misalign <= 1'b0;
        end else if (advance_s) begin
            out_valid    <= req_r.valid;
            out_regWr    <= req_r.reg_wr & req_r.valid & ~req_r.misalign;
            out_regDst   <= dst_r;
            out_wdata    <= wb_data_s;
            out_misalign <= req_r.valid & req_r.misalign;
        end
    end

    // Load data latch: captured on the hit that completes an access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_r <= {DATA_W{1'b0}};
        end else if (access_s && dhit && !flush) begin
            ld_r <= ld_ext_s;
        end
    end

    // Access FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Access FSM next state; a flush abandons any outstanding request.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (advance_s && need_s) begin
                        state_nxt_s = ACCESS;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = ACCESS;
                    end
                end
                DONE: begin
                    if (advance_s) begin
                        state_nxt_s = need_s ? ACCESS : IDLE;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: a 32-bit and a 64-bit instance share
// the same stimulus; each check names the instance it looks at.
module tb_mem_stage_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        flush;
    logic        stall_in;
    logic        in_valid;
    logic        in_regWr;
    logic [4:0]  in_regDst;
    logic [1:0]  in_regSel;
    logic [31:0] in_nPC;
    logic [63:0] in_ALUOut;
    logic        in_dREN;
    logic        in_dWEN;
    logic [1:0]  in_size;
    logic        in_signed;
    logic [63:0] in_store;
    logic [63:0] dmemload;
    logic        dhit;

    logic        dmemREN_a, dmemWEN_a, mem_stall_a;
    logic [31:0] dmemaddr_a, dmemstore_a, out_wdata_a;
    logic [3:0]  dmembyteen_a;
    logic        out_valid_a, out_regWr_a, out_misalign_a;
    logic [4:0]  out_regDst_a;

    logic        dmemREN_b, dmemWEN_b, mem_stall_b;
    logic [63:0] dmemaddr_b, dmemstore_b, out_wdata_b;
    logic [7:0]  dmembyteen_b;
    logic        out_valid_b, out_regWr_b, out_misalign_b;
    logic [4:0]  out_regDst_b;

    int n_total = 0;
    int n_pass  = 0;
    int stall_cnt;

    always #5 CLK = ~CLK;

    mem_stage_pipe #(.DATA_W(32), .REG_W(5), .PC_W(32)) u_dut32 (
        .CLK(CLK), .RST(RST), .flush(flush), .stall_in(stall_in),
        .in_valid(in_valid), .in_regWr(in_regWr), .in_regDst(in_regDst),
        .in_regSel(in_regSel), .in_nPC(in_nPC), .in_ALUOut(in_ALUOut[31:0]),
        .in_dREN(in_dREN), .in_dWEN(in_dWEN), .in_size(in_size),
        .in_signed(in_signed), .in_store(in_store[31:0]),
        .dmemREN(dmemREN_a), .dmemWEN(dmemWEN_a), .dmemaddr(dmemaddr_a),
        .dmemstore(dmemstore_a), .dmembyteen(dmembyteen_a),
        .dmemload(dmemload[31:0]), .dhit(dhit), .mem_stall(mem_stall_a),
        .out_valid(out_valid_a), .out_regWr(out_regWr_a),
        .out_regDst(out_regDst_a), .out_wdata(out_wdata_a),
        .out_misalign(out_misalign_a)
    );

    mem_stage_pipe #(.DATA_W(64), .REG_W(5), .PC_W(32)) u_dut64 (
        .CLK(CLK), .RST(RST), .flush(flush), .stall_in(stall_in),
        .in_valid(in_valid), .in_regWr(in_regWr), .in_regDst(in_regDst),
        .in_regSel(in_regSel), .in_nPC(in_nPC), .in_ALUOut(in_ALUOut),
        .in_dREN(in_dREN), .in_dWEN(in_dWEN), .in_size(in_size),
        .in_signed(in_signed), .in_store(in_store),
        .dmemREN(dmemREN_b), .dmemWEN(dmemWEN_b), .dmemaddr(dmemaddr_b),
        .dmemstore(dmemstore_b), .dmembyteen(dmembyteen_b),
        .dmemload(dmemload), .dhit(dhit), .mem_stall(mem_stall_b),
        .out_valid(out_valid_b), .out_regWr(out_regWr_b),
        .out_regDst(out_regDst_b), .out_wdata(out_wdata_b),
        .out_misalign(out_misalign_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] dst, input logic [1:0] sel, input logic wr,
                            input logic [63:0] alu, input logic ren, input logic wen,
                            input logic [1:0] sz, input logic sg, input logic [63:0] st);
        in_valid  = 1'b1;
        in_regWr  = wr;
        in_regDst = dst;
        in_regSel = sel;
        in_ALUOut = alu;
        in_dREN   = ren;
        in_dWEN   = wen;
        in_size   = sz;
        in_signed = sg;
        in_store  = st;
    endtask

    task automatic clear_op();
        in_valid  = 1'b0;
        in_regWr  = 1'b0;
        in_regDst = 5'd0;
        in_regSel = 2'd0;
        in_nPC    = 32'd0;
        in_ALUOut = 64'd0;
        in_dREN   = 1'b0;
        in_dWEN   = 1'b0;
        in_size   = 2'd0;
        in_signed = 1'b0;
        in_store  = 64'd0;
    endtask

    initial begin
        RST = 1'b1; flush = 1'b0; stall_in = 1'b0; dhit = 1'b0; dmemload = 64'd0;
        clear_op();
        step();
        step();
        check_val("rst_out_valid", out_valid_a, 64'd0);
        check_val("rst_out_regWr", out_regWr_a, 64'd0);
        check_val("rst_out_wdata", out_wdata_a, 64'd0);
        check_val("rst_dmemREN", dmemREN_a, 64'd0);
        check_val("rst_dmemWEN", dmemWEN_a, 64'd0);
        check_val("rst_byteen", dmembyteen_a, 64'd0);
        check_val("rst_mem_stall", mem_stall_a, 64'd0);
        check_val("rst_out_wdata64", out_wdata_b, 64'd0);
        RST = 1'b0;

        // ALU op: result appears one edge after capture
        drive_op(5'd7, 2'd0, 1'b1, 64'h1234, 1'b0, 1'b0, 2'd2, 1'b0, 64'd0);
        step();
        clear_op();
        check_val("alu_stall0", mem_stall_a, 64'd0);
        step();
        check_val("alu_stall1", mem_stall_a, 64'd0);
        check_val("alu_wdata", out_wdata_a, 64'h1234);
        check_val("alu_regDst", out_regDst_a, 64'd7);
        check_val("alu_regWr", out_regWr_a, 64'd1);
        check_val("alu_valid", out_valid_a, 64'd1);
        check_val("alu_wdata64", out_wdata_b, 64'h1234);

        // link value select
        drive_op(5'd31, 2'd2, 1'b1, 64'hFFFF, 1'b0, 1'b0, 2'd2, 1'b0, 64'd0);
        in_nPC = 32'h404;
        step();
        clear_op();
        step();
        check_val("npc_wdata", out_wdata_a, 64'h404);
        check_val("npc_regDst", out_regDst_a, 64'd31);
        check_val("npc_wdata64", out_wdata_b, 64'h404);

        // LB signed at 0x103, hit on the third request cycle
        drive_op(5'd3, 2'd1, 1'b1, 64'h103, 1'b1, 1'b0, 2'd0, 1'b1, 64'd0);
        step();
        clear_op();
        dmemload = 64'h80FFFFFF;
        check_val("lb_dmemREN", dmemREN_a, 64'd1);
        check_val("lb_dmemWEN", dmemWEN_a, 64'd0);
        check_val("lb_addr", dmemaddr_a, 64'h100);
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (mem_stall_a) stall_cnt++;
            dhit = (i == 2);
            step();
        end
        dhit = 1'b0;
        check_val("lb_stall_cycles", stall_cnt, 64'd3);
        check_val("lb_stall_done", mem_stall_a, 64'd0);
        check_val("lb_req_dropped", dmemREN_a, 64'd0);
        check_val("lb_not_yet_wb", out_valid_a, 64'd0);
        step();
        check_val("lb_wdata", out_wdata_a, 64'hFFFFFF80);
        check_val("lb_regWr", out_regWr_a, 64'd1);
        check_val("lb_regDst", out_regDst_a, 64'd3);
        check_val("lb_valid", out_valid_a, 64'd1);
        check_val("lb_wdata64", out_wdata_b, 64'hFFFFFFFFFFFFFF80);

        // SH at 0x102
        drive_op(5'd0, 2'd0, 1'b0, 64'h102, 1'b0, 1'b1, 2'd1, 1'b0, 64'hABCD);
        step();
        clear_op();
        check_val("sh_dmemWEN", dmemWEN_a, 64'd1);
        check_val("sh_dmemREN", dmemREN_a, 64'd0);
        check_val("sh_store", dmemstore_a, 64'hABCDABCD);
        check_val("sh_byteen", dmembyteen_a, 64'hC);
        check_val("sh_addr", dmemaddr_a, 64'h100);
        check_val("sh_store64", dmemstore_b, 64'hABCDABCDABCDABCD);
        check_val("sh_byteen64", dmembyteen_b, 64'h0C);
        step();
        check_val("sh_wen_held", dmemWEN_a, 64'd1);
        check_val("sh_store_held", dmemstore_a, 64'hABCDABCD);
        check_val("sh_stall_held", mem_stall_a, 64'd1);
        dhit = 1'b1;
        step();
        dhit = 1'b0;
        check_val("sh_wen_drop", dmemWEN_a, 64'd0);
        check_val("sh_byteen_drop", dmembyteen_a, 64'd0);
        step();
        check_val("sh_valid", out_valid_a, 64'd1);
        check_val("sh_regWr", out_regWr_a, 64'd0);

        // LW misaligned at 0x102
        drive_op(5'd5, 2'd1, 1'b1, 64'h102, 1'b1, 1'b0, 2'd2, 1'b0, 64'd0);
        step();
        clear_op();
        check_val("mis_dmemREN", dmemREN_a, 64'd0);
        check_val("mis_stall", mem_stall_a, 64'd0);
        step();
        check_val("mis_flag", out_misalign_a, 64'd1);
        check_val("mis_regWr", out_regWr_a, 64'd0);
        check_val("mis_valid", out_valid_a, 64'd1);
        check_val("mis_flag64", out_misalign_b, 64'd1);

        // flush mid-ACCESS with a same-cycle hit
        drive_op(5'd9, 2'd1, 1'b1, 64'h200, 1'b1, 1'b0, 2'd2, 1'b0, 64'd0);
        step();
        clear_op();
        check_val("fl_dmemREN", dmemREN_a, 64'd1);
        check_val("fl_stall", mem_stall_a, 64'd1);
        flush = 1'b1;
        dhit = 1'b1;
        dmemload = 64'hDEADBEEF;
        step();
        flush = 1'b0;
        dhit = 1'b0;
        check_val("fl_req_drop", dmemREN_a, 64'd0);
        check_val("fl_stall_drop", mem_stall_a, 64'd0);
        check_val("fl_out_valid", out_valid_a, 64'd0);
        check_val("fl_out_wdata", out_wdata_a, 64'd0);
        step();
        check_val("fl_req_idle", dmemREN_a, 64'd0);
        check_val("fl_out_valid2", out_valid_a, 64'd0);

        // 64-bit LD at 0x8 with stall_in held two cycles after the hit
        drive_op(5'd12, 2'd1, 1'b1, 64'h8, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0);
        step();
        clear_op();
        check_val("ld_dmemREN64", dmemREN_b, 64'd1);
        check_val("ld_addr64", dmemaddr_b, 64'h8);
        check_val("ld_stall64", mem_stall_b, 64'd1);
        check_val("ld_dword32_noreq", dmemREN_a, 64'd0);
        check_val("ld_dword32_nostall", mem_stall_a, 64'd0);
        dmemload = 64'h8877665544332211;
        dhit = 1'b1;
        stall_in = 1'b1;
        step();
        dhit = 1'b0;
        dmemload = 64'd0;
        check_val("ld_stall_done64", mem_stall_b, 64'd0);
        check_val("ld_held_valid_a", out_valid_b, 64'd0);
        step();
        check_val("ld_held_valid_b", out_valid_b, 64'd0);
        step();
        check_val("ld_held_valid_c", out_valid_b, 64'd0);
        stall_in = 1'b0;
        step();
        check_val("ld_wdata64", out_wdata_b, 64'h8877665544332211);
        check_val("ld_regWr64", out_regWr_b, 64'd1);
        check_val("ld_regDst64", out_regDst_b, 64'd12);
        check_val("ld_dword32_mis", out_misalign_a, 64'd1);
        check_val("ld_dword32_regWr", out_regWr_a, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
